cnn_mac_requant: RTL and testbench
==================================

Name: cnn_mac_requant

Overview:
- Downstream consumer of the 16s x 11s signed product stream (28-bit, 20 fractional bits) in the conv/dense datapath.
- Accumulates one output pixel's window of products and adds a per-window bias.
- Rounds and saturates the sum to the W16/I6 activation format (16-bit, 10 fractional bits), with optional ReLU.
- Emits one result per window over a valid/ready handshake to the activation store.

Parameters:
- PROD_W, 28, product input width (signed).
- PROD_FRAC, 20, fractional bits of product.
- OUT_W, 16, output width (signed).
- OUT_FRAC, 10, fractional bits of output and bias.
- ACC_W, 40, accumulator width (signed). Must be at least PROD_W + clog2(MAX_TAPS) + 1.
- MAX_TAPS, 256, longest window. The window is force-closed when this count is reached.
- RELU_EN, 1, clamp negative results to 0.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- prod_din  in  PROD_W  signed product.
- prod_valid  in  1  product valid.
- prod_last  in  1  final tap of window.
- prod_ready  out  1  product accepted when valid&ready.
- bias_din  in  OUT_W  signed bias. Sampled with the first tap of each window.
- out_data  out  OUT_W  requantised result.
- out_sat  out  1  result was saturated.
- out_taps  out  clog2(MAX_TAPS)+1  tap count of the window.
- out_valid  out  1  result valid.
- out_ready  in  1  sink ready.

Behaviour:
- One clock domain, reset is asynchronous active-low.
- Reset values:
  - FSM = S_ACC, first = 1, acc = 0, tap count = 0.
  - out_valid = 0, out_data = 0, out_sat = 0, out_taps = 0.
  - prod_ready = 0 while ap_rst_n is low, 1 from the first cycle after release.
- SHIFT = PROD_FRAC - OUT_FRAC (10). Bias is sign-extended to ACC_W and left-shifted by SHIFT.
- FSM states:
  - S_ACC: prod_ready = 1. On each accept:
    - acc <= (first ? bias_aligned : acc) + sext(prod_din).
    - cnt <= (first ? 1 : cnt + 1).
    - first <= 0.
    - If prod_last = 1, or the accepted tap is number MAX_TAPS: go to S_RND.
  - S_RND: prod_ready = 0. Compute:
    - r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic shift).
    - If RELU_EN and r < 0: r = 0, out_sat = 0.
    - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat = 1 if clipped.
    - Register out_data, out_sat and out_taps = cnt; out_valid <= 1; go to S_OUT.
  - S_OUT: prod_ready = 0, out_valid = 1. Outputs are held stable until out_ready = 1. On that cycle's edge: out_valid <= 0, first <= 1, go to S_ACC.
- Latency and throughput:
  - Last tap accepted at edge k → out_valid high after edge k+1 (visible for cycle k+1..k+2 at the earliest).
  - Minimum window period is N+2 cycles. There is no overlap between windows.
- Boundary conditions:
  - prod_valid with prod_ready = 0 is ignored; upstream must hold the product.
  - A one-tap window (prod_last on the first tap) is legal: result = bias + prod.
  - Force-close at MAX_TAPS: the window ends on that tap, out_taps = MAX_TAPS. The next tap starts a new window even if prod_last was never seen.
  - The accumulator never overflows given the ACC_W rule. Only the output stage saturates.
  - Reset asserted mid-window or mid-hold: everything returns to reset values immediately and the partial window is discarded.
  - bias_din is ignored except on the first tap of a window.

Decomposition:
- Shared package cnn_fixed_pkg holds:
  - Format constants (W16/I6: OUT_W, OUT_FRAC; PROD_W, PROD_FRAC).
  - The FSM state encoding.
  - A round/saturate function shared with the pooling stage.
- One natural sub-module: cnn_round_sat. It is combinational: arithmetic shift with round-half-up, optional ReLU, saturate, and sat flag. It is instantiated in S_RND.

Test Plan:
- Three taps of 1048576 (1.0), bias 0, last on tap 3 → out_data 3072, out_sat 0, out_taps 3, out_valid one cycle after the last accept edge.
- Rounding, bias 0, single tap each:
  - prod 512 → out_data 1.
  - prod 511 → out_data 0.
  - prod -512 with RELU_EN=0 → out_data 0.
  - prod -513 with RELU_EN=0 → out_data -1.
- Saturation and ReLU:
  - bias 32767 + prod 1048576 → out_data 32767, out_sat 1.
  - bias -32768 + prod -1048576 with RELU_EN=0 → -32768, out_sat 1.
  - bias -32768 + prod -1048576 with RELU_EN=1 → 0, out_sat 0.
- Backpressure: hold out_ready low 5 cycles with prod_valid high → out_data stable, prod_ready 0, no product consumed. Release → next window starts and uses the new bias_din.
- MAX_TAPS=4 build: 6 taps of 1048576, no prod_last, bias 0 → first result 4096 with out_taps 4. The remaining 2 taps accumulate into the next window.
- Assert ap_rst_n low after 2 taps of a window → out_valid 0 immediately. After release, a 1-tap window of 1048576 with bias 0 yields 1024, with no residue from the aborted window.

Source files
------------

// File: rtl/cnn_fixed_pkg.sv
// Fixed-point formats, FSM encoding and the round/saturate helper shared by the
// conv/dense requant stage and the pooling stage.
package cnn_fixed_pkg;

  localparam int FX_PROD_W    = 28;
  localparam int FX_PROD_FRAC = 20;
  localparam int FX_OUT_W     = 16;
  localparam int FX_OUT_FRAC  = 10;
  localparam int FX_SHIFT     = FX_PROD_FRAC - FX_OUT_FRAC;
  localparam int RS_W         = 64;

  localparam logic signed [RS_W-1:0] OUT_MAX = (64'sd1 <<< (FX_OUT_W - 1)) - 64'sd1;
  localparam logic signed [RS_W-1:0] OUT_MIN = -(64'sd1 <<< (FX_OUT_W - 1));

  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_RND = 2'd1,
    S_OUT = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [FX_OUT_W-1:0] data;
    logic                       sat;
  } rs_t;

  // Round half up, optional ReLU, then clip to the W16/I6 range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc, input logic relu);
    logic signed [RS_W-1:0] r;
    rs_t res;
    r = (acc + (64'sd1 <<< (FX_SHIFT - 1))) >>> FX_SHIFT;
    res.sat = 1'b0;
    if (relu && (r < 0))
      r = '0;
    if (r > OUT_MAX) begin
      res.data = OUT_MAX[FX_OUT_W-1:0];
      res.sat  = 1'b1;
    end else if (r < OUT_MIN) begin
      res.data = OUT_MIN[FX_OUT_W-1:0];
      res.sat  = 1'b1;
    end else begin
      res.data = r[FX_OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cnn_round_sat.sv
// Combinational requantiser: accumulator (product scale) to W16/I6 activation.
module cnn_round_sat
  import cnn_fixed_pkg::*;
#(
  parameter int ACC_W   = 40,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0]    acc,
  output logic signed [FX_OUT_W-1:0] data,
  output logic                       sat
);

  rs_t rs;

  assign rs   = round_sat({{(RS_W-ACC_W){acc[ACC_W-1]}}, acc}, RELU_EN);
  assign data = rs.data;
  assign sat  = rs.sat;

endmodule

// File: rtl/cnn_mac_requant.sv
// Window accumulator with per-window bias, followed by round/saturate/ReLU and a
// held valid/ready result towards the activation store.
module cnn_mac_requant
  import cnn_fixed_pkg::*;
#(
  parameter int PROD_W    = FX_PROD_W,
  parameter int PROD_FRAC = FX_PROD_FRAC,
  parameter int OUT_W     = FX_OUT_W,
  parameter int OUT_FRAC  = FX_OUT_FRAC,
  parameter int ACC_W     = 40,
  parameter int MAX_TAPS  = 256,
  parameter bit RELU_EN   = 1'b1,
  parameter int CNT_W     = $clog2(MAX_TAPS) + 1
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic signed [PROD_W-1:0] prod_din,
  input  logic                     prod_valid,
  input  logic                     prod_last,
  output logic                     prod_ready,
  input  logic signed [OUT_W-1:0]  bias_din,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic [CNT_W-1:0]         out_taps,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int SHIFT = PROD_FRAC - OUT_FRAC;

  state_t                   state, state_nxt;
  logic                     ready_en;
  logic                     first;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic                     accept, close;
  logic [CNT_W-1:0]         cnt_nxt;
  logic signed [ACC_W-1:0]  bias_aligned, prod_ext, acc_base;
  logic signed [OUT_W-1:0]  rs_data;
  logic                     rs_sat;

  assign accept       = prod_valid & prod_ready;
  assign cnt_nxt      = first ? CNT_W'(1) : cnt + CNT_W'(1);
  assign close        = accept & (prod_last | (cnt_nxt == CNT_W'(MAX_TAPS)));
  assign bias_aligned = {{(ACC_W-OUT_W){bias_din[OUT_W-1]}}, bias_din} <<< SHIFT;
  assign prod_ext     = {{(ACC_W-PROD_W){prod_din[PROD_W-1]}}, prod_din};
  assign acc_base     = first ? bias_aligned : acc;

  cnn_round_sat #(
    .ACC_W   (ACC_W),
    .RELU_EN (RELU_EN)
  ) u_round_sat (
    .acc  (acc),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      state <= S_ACC;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_ACC:   if (close) state_nxt = S_RND;
      S_RND:   state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  // ready_en keeps the input closed while reset is held and for the release cycle.
  always_comb begin
    prod_ready = ready_en & (state == S_ACC);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ready_en  <= 1'b0;
      first     <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_taps  <= '0;
      out_valid <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        acc   <= acc_base + prod_ext;
        cnt   <= cnt_nxt;
        first <= 1'b0;
      end
      if (state == S_RND) begin
        out_data  <= rs_data;
        out_sat   <= rs_sat;
        out_taps  <= cnt;
        out_valid <= 1'b1;
      end
      if ((state == S_OUT) && out_ready) begin
        out_valid <= 1'b0;
        first     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnn_mac_requant.sv
// Directed bench for cnn_mac_requant: default build, a RELU_EN=0 build and a MAX_TAPS=4 build.
module tb_cnn_mac_requant;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic signed [27:0] prod_din = '0;
  logic               prod_valid = 1'b0;
  logic               prod_last = 1'b0;
  logic signed [15:0] bias_din = '0;
  logic               out_ready = 1'b0;
  int                 sel = 0;

  int vectors = 0;
  int miscompares = 0;

  always #5 ap_clk = ~ap_clk;

  logic               pv0, pv1, pv2, or0, or1, or2;
  logic               pr0, pr1, pr2, os0, os1, os2, ov0, ov1, ov2;
  logic signed [15:0] od0, od1, od2;
  logic [8:0]         ot0, ot1;
  logic [2:0]         ot2;

  logic               mon_ready, mon_sat, mon_valid;
  logic signed [15:0] mon_data;
  logic [8:0]         mon_taps;

  always_comb begin
    pv0 = prod_valid && (sel == 0);
    pv1 = prod_valid && (sel == 1);
    pv2 = prod_valid && (sel == 2);
    or0 = (sel == 0) ? out_ready : 1'b1;
    or1 = (sel == 1) ? out_ready : 1'b1;
    or2 = (sel == 2) ? out_ready : 1'b1;
    case (sel)
      1: begin mon_ready = pr1; mon_data = od1; mon_sat = os1; mon_taps = ot1; mon_valid = ov1; end
      2: begin mon_ready = pr2; mon_data = od2; mon_sat = os2; mon_taps = {6'b0, ot2}; mon_valid = ov2; end
      default: begin mon_ready = pr0; mon_data = od0; mon_sat = os0; mon_taps = ot0; mon_valid = ov0; end
    endcase
  end

  cnn_mac_requant dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_din(prod_din), .prod_valid(pv0),
    .prod_last(prod_last), .prod_ready(pr0), .bias_din(bias_din), .out_data(od0),
    .out_sat(os0), .out_taps(ot0), .out_valid(ov0), .out_ready(or0));

  cnn_mac_requant #(.RELU_EN(1'b0)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_din(prod_din), .prod_valid(pv1),
    .prod_last(prod_last), .prod_ready(pr1), .bias_din(bias_din), .out_data(od1),
    .out_sat(os1), .out_taps(ot1), .out_valid(ov1), .out_ready(or1));

  cnn_mac_requant #(.MAX_TAPS(4)) dut2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_din(prod_din), .prod_valid(pv2),
    .prod_last(prod_last), .prod_ready(pr2), .bias_din(bias_din), .out_data(od2),
    .out_sat(os2), .out_taps(ot2), .out_valid(ov2), .out_ready(or2));

  task automatic send_tap(input logic signed [27:0] p, input logic l, input logic signed [15:0] b);
    int n = 0;
    prod_din = p; prod_last = l; bias_din = b; prod_valid = 1'b1;
    while (!mon_ready && n < 50) begin
      @(posedge ap_clk); #1; n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL tap_accept_timeout: prod_ready=%0b after %0d cycles, required 1", mon_ready, n);
    end
    @(posedge ap_clk); #1;
    prod_valid = 1'b0; prod_last = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!mon_valid && n < 50) begin
      @(posedge ap_clk); #1; n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL result_timeout: out_valid=%0b after %0d cycles, required 1", mon_valid, n);
    end
  endtask

  task automatic take_result(output logic signed [15:0] d, output logic s, output logic [8:0] t);
    wait_valid();
    d = mon_data; s = mon_sat; t = mon_taps;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    vectors++; if (mon_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b want 0", mon_valid); end
    vectors++; if (mon_data !== 16'sd0) begin miscompares++; $display("FAIL rst_data: got %0d want 0", mon_data); end
    vectors++; if (mon_sat !== 1'b0) begin miscompares++; $display("FAIL rst_sat: got %0b want 0", mon_sat); end
    vectors++; if (mon_taps !== 9'd0) begin miscompares++; $display("FAIL rst_taps: got %0d want 0", mon_taps); end
    vectors++; if (mon_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_low: got %0b want 0", mon_ready); end
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    vectors++; if (mon_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_release: got %0b want 1", mon_ready); end
  endtask

  task automatic test_three_taps();
    sel = 0;
    send_tap(28'sd1048576, 1'b0, 16'sd0);
    send_tap(28'sd1048576, 1'b0, 16'sd999);
    send_tap(28'sd1048576, 1'b1, 16'sd999);
    vectors++; if (mon_valid !== 1'b0) begin miscompares++; $display("FAIL three_early_valid: got %0b want 0", mon_valid); end
    @(posedge ap_clk); #1;
    vectors++; if (mon_valid !== 1'b1) begin miscompares++; $display("FAIL three_latency: got %0b want 1", mon_valid); end
    vectors++; if (mon_data !== 16'sd3072) begin miscompares++; $display("FAIL three_data: got %0d want 3072", mon_data); end
    vectors++; if (mon_sat !== 1'b0) begin miscompares++; $display("FAIL three_sat: got %0b want 0", mon_sat); end
    vectors++; if (mon_taps !== 9'd3) begin miscompares++; $display("FAIL three_taps: got %0d want 3", mon_taps); end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    vectors++; if (mon_valid !== 1'b0) begin miscompares++; $display("FAIL three_valid_drop: got %0b want 0", mon_valid); end
  endtask

  task automatic test_rounding();
    int prods [4] = '{512, 511, -512, -513};
    int exps  [4] = '{1, 0, 0, -1};
    logic signed [15:0] d; logic s; logic [8:0] t;
    sel = 1;
    for (int i = 0; i < 4; i++) begin
      send_tap(28'(prods[i]), 1'b1, 16'sd0);
      take_result(d, s, t);
      vectors++; if (d !== 16'(exps[i])) begin miscompares++; $display("FAIL round_%0d: got %0d want %0d", prods[i], d, exps[i]); end
      vectors++; if (s !== 1'b0) begin miscompares++; $display("FAIL round_sat_%0d: got %0b want 0", prods[i], s); end
    end
  endtask

  task automatic test_saturation();
    int sels  [3] = '{0, 1, 0};
    int biases[3] = '{32767, -32768, -32768};
    int prods [3] = '{1048576, -1048576, -1048576};
    int exps  [3] = '{32767, -32768, 0};
    logic esat[3] = '{1'b1, 1'b1, 1'b0};
    logic signed [15:0] d; logic s; logic [8:0] t;
    for (int i = 0; i < 3; i++) begin
      sel = sels[i];
      send_tap(28'(prods[i]), 1'b1, 16'(biases[i]));
      take_result(d, s, t);
      vectors++; if (d !== 16'(exps[i])) begin miscompares++; $display("FAIL sat_data_%0d: got %0d want %0d", i, d, exps[i]); end
      vectors++; if (s !== esat[i]) begin miscompares++; $display("FAIL sat_flag_%0d: got %0b want %0b", i, s, esat[i]); end
      vectors++; if (t !== 9'd1) begin miscompares++; $display("FAIL sat_taps_%0d: got %0d want 1", i, t); end
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] d; logic s; logic [8:0] t;
    sel = 0;
    send_tap(28'sd1048576, 1'b1, 16'sd0);
    wait_valid();
    prod_din = 28'sd2097152; prod_last = 1'b1; bias_din = 16'sd100; prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (mon_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_%0d: got %0b want 1", i, mon_valid); end
      vectors++; if (mon_data !== 16'sd1024) begin miscompares++; $display("FAIL bp_data_%0d: got %0d want 1024", i, mon_data); end
      vectors++; if (mon_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_%0d: got %0b want 0", i, mon_ready); end
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    vectors++; if (mon_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %0b want 0", mon_valid); end
    vectors++; if (mon_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %0b want 1", mon_ready); end
    @(posedge ap_clk); #1;
    prod_valid = 1'b0; prod_last = 1'b0; bias_din = -16'sd5;
    take_result(d, s, t);
    vectors++; if (d !== 16'sd2148) begin miscompares++; $display("FAIL bp_next_data: got %0d want 2148", d); end
    vectors++; if (t !== 9'd1) begin miscompares++; $display("FAIL bp_next_taps: got %0d want 1", t); end
  endtask

  task automatic test_force_close();
    logic signed [15:0] d; logic s; logic [8:0] t;
    sel = 2;
    for (int i = 0; i < 4; i++) send_tap(28'sd1048576, 1'b0, 16'sd0);
    take_result(d, s, t);
    vectors++; if (d !== 16'sd4096) begin miscompares++; $display("FAIL fc_data: got %0d want 4096", d); end
    vectors++; if (t !== 9'd4) begin miscompares++; $display("FAIL fc_taps: got %0d want 4", t); end
    send_tap(28'sd1048576, 1'b0, 16'sd0);
    send_tap(28'sd1048576, 1'b0, 16'sd0);
    send_tap(28'sd1048576, 1'b1, 16'sd0);
    take_result(d, s, t);
    vectors++; if (d !== 16'sd3072) begin miscompares++; $display("FAIL fc_next_data: got %0d want 3072", d); end
    vectors++; if (t !== 9'd3) begin miscompares++; $display("FAIL fc_next_taps: got %0d want 3", t); end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] d; logic s; logic [8:0] t;
    sel = 0;
    send_tap(28'sd1048576, 1'b1, 16'sd0);
    wait_valid();
    ap_rst_n = 1'b0;
    #1;
    vectors++; if (mon_valid !== 1'b0) begin miscompares++; $display("FAIL hold_rst_valid: got %0b want 0", mon_valid); end
    vectors++; if (mon_data !== 16'sd0) begin miscompares++; $display("FAIL hold_rst_data: got %0d want 0", mon_data); end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    send_tap(28'sd5242880, 1'b0, 16'sd0);
    send_tap(28'sd5242880, 1'b0, 16'sd0);
    ap_rst_n = 1'b0;
    #1;
    vectors++; if (mon_valid !== 1'b0) begin miscompares++; $display("FAIL win_rst_valid: got %0b want 0", mon_valid); end
    vectors++; if (mon_ready !== 1'b0) begin miscompares++; $display("FAIL win_rst_ready: got %0b want 0", mon_ready); end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    send_tap(28'sd1048576, 1'b1, 16'sd0);
    take_result(d, s, t);
    vectors++; if (d !== 16'sd1024) begin miscompares++; $display("FAIL post_rst_data: got %0d want 1024", d); end
    vectors++; if (t !== 9'd1) begin miscompares++; $display("FAIL post_rst_taps: got %0d want 1", t); end
  endtask

  initial begin
    test_reset();
    test_three_taps();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_force_close();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
